// File: rtl/controle_pkg.sv
// Shared definitions for the multi-pad Mega Drive gamepad reader:
// button bit positions, scan states, select-phase indices and the
// helper that turns captured samples into the vector fed to debounce.
package controle_pkg;

  // Bit positions inside each 12-bit per-pad button vector
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_B     = 4;
  localparam int BTN_C     = 5;
  localparam int BTN_A     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_Z     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_X     = 10;
  localparam int BTN_MODE  = 11;
  localparam int N_BTN     = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Select phases that carry information
  localparam logic [2:0] PH_DIR = 3'd0;  // Select high: D-pad, B, C
  localparam logic [2:0] PH_AST = 3'd1;  // Select low: A, Start, presence
  localparam logic [2:0] PH_ID  = 3'd5;  // third low: 6-button signature
  localparam logic [2:0] PH_XYZ = 3'd6;  // following high: X, Y, Z, Mode

  // Vector handed to the debouncer: extended buttons only exist on an
  // identified 6-button pad, and an absent pad reads as nothing pressed.
  function automatic logic [N_BTN-1:0] frame_vector(input logic [N_BTN-1:0] raw,
                                                     input logic present,
                                                     input logic six,
                                                     input logic six_en);
    logic [N_BTN-1:0] v;
    v = raw;
    if (!(six && six_en)) begin
      v[BTN_MODE:BTN_Z] = 4'b0000;
    end else begin
      v[BTN_MODE:BTN_Z] = raw[BTN_MODE:BTN_Z];
    end
    if (!present) begin
      v = 12'h000;
    end else begin
      v = v;
    end
    return v;
  endfunction

endpackage

// File: rtl/controle_debounce.sv
// Per-pad frame debouncer: a new button vector must be seen on
// DEBOUNCE_FRAMES consecutive commits before it reaches saidas;
// pressionado pulses for one cycle on each newly set button.
module controle_debounce
  import controle_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit,
  input  logic [N_BTN-1:0] raw,
  output logic [N_BTN-1:0] saidas,
  output logic [N_BTN-1:0] pressionado
);

  localparam int CNTW = (DEBOUNCE_FRAMES > 0) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEBOUNCE_FRAMES);

  logic [N_BTN-1:0] cand_r;
  logic [N_BTN-1:0] saidas_r;
  logic [N_BTN-1:0] press_r;
  logic [CNTW-1:0]  cnt_r;
  logic [N_BTN-1:0] cand_nxt_s;
  logic [N_BTN-1:0] saidas_nxt_s;
  logic [CNTW-1:0]  cnt_nxt_s;

  // Candidate tracking and saturating agreement count for this frame
  always_comb begin
    cand_nxt_s   = cand_r;
    cnt_nxt_s    = cnt_r;
    saidas_nxt_s = saidas_r;
    if (raw == cand_r) begin
      cand_nxt_s = cand_r;
      if (cnt_r >= CNT_MAX) begin
        cnt_nxt_s = CNT_MAX;
      end else begin
        cnt_nxt_s = cnt_r + CNTW'(1);
      end
    end else begin
      cand_nxt_s = raw;
      cnt_nxt_s  = CNTW'(1);
    end
    if (cnt_nxt_s == CNT_MAX) begin
      saidas_nxt_s = cand_nxt_s;
    end else begin
      saidas_nxt_s = saidas_r;
    end
  end

  // Update debounce state on commit; press pulse lasts one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_r   <= 12'h000;
      cnt_r    <= '0;
      saidas_r <= 12'h000;
      press_r  <= 12'h000;
    end else if (commit) begin
      cand_r   <= cand_nxt_s;
      cnt_r    <= cnt_nxt_s;
      saidas_r <= saidas_nxt_s;
      press_r  <= saidas_nxt_s & ~saidas_r;
    end else begin
      press_r  <= 12'h000;
    end
  end

  assign saidas      = saidas_r;
  assign pressionado = press_r;

endmodule

// File: rtl/controle_gamepad.sv
// Multi-pad Mega Drive/Genesis gamepad reader. Each v_sync rising edge
// launches one scan of the shared Select line (8 phases for 6-button
// support, 2 otherwise); samples are committed through a per-pad debouncer.
module controle_gamepad
  import controle_pkg::*;
#(
  parameter int N_PADS          = 2,
  parameter int SETTLE_CYCLES   = 500,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int SIX_BUTTON      = 1
) (
  input  logic                      Clock50,
  input  logic                      Reset,
  input  logic                      v_sync,
  input  logic [6*N_PADS-1:0]       Pinos,
  output logic                      Select,
  output logic [N_BTN*N_PADS-1:0]   Saidas,
  output logic [N_BTN*N_PADS-1:0]   Pressionado,
  output logic [N_PADS-1:0]         Presente,
  output logic [N_PADS-1:0]         SeisBotoes,
  output logic                      Quadro,
  output logic                      Ocupado
);

  localparam int N_PHASES = (SIX_BUTTON != 0) ? 8 : 2;
  localparam int CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CYC = CW'(SETTLE_CYCLES - 1);
  localparam logic [2:0]    LAST_PH  = 3'(N_PHASES - 1);
  localparam logic          SIX_EN   = (SIX_BUTTON != 0) ? 1'b1 : 1'b0;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] cyc_r;
  logic [2:0]    phase_r;
  logic          select_r;
  logic          ocupado_r;
  logic          quadro_r;
  logic          vs_meta_r;
  logic          vs_sync_r;
  logic          vs_prev_r;
  logic          vs_rise_s;
  logic          phase_end_s;
  logic          scan_start_s;
  logic          sample_s;
  logic          commit_s;

  // Two-flop synchroniser for v_sync plus the edge-detect history flop
  always_ff @(posedge Clock50) begin
    if (Reset) begin
      vs_meta_r <= 1'b0;
      vs_sync_r <= 1'b0;
      vs_prev_r <= 1'b0;
    end else begin
      vs_meta_r <= v_sync;
      vs_sync_r <= vs_meta_r;
      vs_prev_r <= vs_sync_r;
    end
  end

  assign vs_rise_s    = vs_sync_r & ~vs_prev_r;
  assign phase_end_s  = (cyc_r == LAST_CYC);
  assign scan_start_s = (state_r == IDLE) && vs_rise_s;
  assign sample_s     = (state_r == SCAN) && phase_end_s;
  assign commit_s     = (state_r == COMMIT);

  // Next-state logic; edges arriving outside IDLE are simply dropped
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (vs_rise_s) begin
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (phase_end_s && (phase_r == LAST_PH)) begin
          state_nxt_s = COMMIT;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      COMMIT:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, phase/cycle counters, registered Select and status strobes
  always_ff @(posedge Clock50) begin
    if (Reset) begin
      state_r   <= IDLE;
      cyc_r     <= '0;
      phase_r   <= 3'd0;
      select_r  <= 1'b1;
      ocupado_r <= 1'b0;
      quadro_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ocupado_r <= (state_nxt_s != IDLE);
      quadro_r  <= commit_s;
      if (state_r == SCAN) begin
        if (phase_end_s) begin
          cyc_r    <= '0;
          phase_r  <= phase_r + 3'd1;
          // next phase is even (Select high) exactly when this one is odd
          select_r <= phase_r[0];
        end else begin
          cyc_r    <= cyc_r + CW'(1);
        end
      end else begin
        cyc_r    <= '0;
        phase_r  <= 3'd0;
        select_r <= 1'b1;
      end
    end
  end

  assign Select  = select_r;
  assign Ocupado = ocupado_r;
  assign Quadro  = quadro_r;

  for (genvar p = 0; p < N_PADS; p++) begin : g_pad
    logic [5:0]       pins_s;     // {P9,P6,P4,P3,P2,P1}, active-low
    logic [N_BTN-1:0] raw_r;
    logic             pres_raw_r;
    logic             six_raw_r;
    logic             present_r;
    logic             six_r;
    logic [N_BTN-1:0] frame_s;
    logic             six_eff_s;

    assign pins_s    = Pinos[6*p +: 6];
    assign frame_s   = frame_vector(raw_r, pres_raw_r, six_raw_r, SIX_EN);
    assign six_eff_s = pres_raw_r & six_raw_r & SIX_EN;

    // Capture inverted pin samples on the last cycle of each phase
    always_ff @(posedge Clock50) begin
      if (Reset) begin
        raw_r      <= 12'h000;
        pres_raw_r <= 1'b0;
        six_raw_r  <= 1'b0;
      end else if (scan_start_s) begin
        raw_r      <= 12'h000;
        pres_raw_r <= 1'b0;
        six_raw_r  <= 1'b0;
      end else if (sample_s) begin
        case (phase_r)
          PH_DIR: begin
            raw_r[BTN_UP]    <= ~pins_s[0];
            raw_r[BTN_DOWN]  <= ~pins_s[1];
            raw_r[BTN_LEFT]  <= ~pins_s[2];
            raw_r[BTN_RIGHT] <= ~pins_s[3];
            raw_r[BTN_B]     <= ~pins_s[4];
            raw_r[BTN_C]     <= ~pins_s[5];
          end
          PH_AST: begin
            raw_r[BTN_A]     <= ~pins_s[4];
            raw_r[BTN_START] <= ~pins_s[5];
            pres_raw_r       <= (pins_s[3:2] == 2'b00);
          end
          PH_ID: begin
            six_raw_r <= (pins_s[3:0] == 4'b0000);
          end
          PH_XYZ: begin
            if (six_raw_r && SIX_EN) begin
              raw_r[BTN_Z]    <= ~pins_s[0];
              raw_r[BTN_Y]    <= ~pins_s[1];
              raw_r[BTN_X]    <= ~pins_s[2];
              raw_r[BTN_MODE] <= ~pins_s[3];
            end
          end
          default: begin
          end
        endcase
      end
    end

    // Presence and pad type follow each frame directly, without debounce
    always_ff @(posedge Clock50) begin
      if (Reset) begin
        present_r <= 1'b0;
        six_r     <= 1'b0;
      end else if (commit_s) begin
        present_r <= pres_raw_r;
        six_r     <= six_eff_s;
      end
    end

    assign Presente[p]   = present_r;
    assign SeisBotoes[p] = six_r;

    controle_debounce #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
      .clk         (Clock50),
      .reset       (Reset),
      .commit      (commit_s),
      .raw         (frame_s),
      .saidas      (Saidas[N_BTN*p +: N_BTN]),
      .pressionado (Pressionado[N_BTN*p +: N_BTN])
    );
  end

endmodule

// File: tb/tb_controle_gamepad.sv
// Self-checking bench for controle_gamepad with behavioural 3/6-button
// pad models on both ports, a frame table checked through a scoreboard
// queue, and hand-written timing, reset and ignored-edge sequences.
module tb_controle_gamepad;
  import controle_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_sync;
  logic [11:0] pinos;
  logic        sel;
  logic [23:0] saidas;
  logic [23:0] press;
  logic [1:0]  presente;
  logic [1:0]  seis;
  logic        quadro;
  logic        ocupado;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  controle_gamepad #(
    .N_PADS(2), .SETTLE_CYCLES(4), .DEBOUNCE_FRAMES(2), .SIX_BUTTON(1)
  ) dut (
    .Clock50(clk), .Reset(rst), .v_sync(v_sync), .Pinos(pinos),
    .Select(sel), .Saidas(saidas), .Pressionado(press),
    .Presente(presente), .SeisBotoes(seis), .Quadro(quadro), .Ocupado(ocupado)
  );

  // pad kinds: 0 absent, 1 three-button, 2 six-button
  logic [1:0]  kind0, kind1;
  logic [11:0] btn0, btn1;
  int          falls;
  logic        sel_prev;

  // Count Select falling edges within a scan, as a real 6-button pad does
  always @(posedge clk) begin
    sel_prev <= sel;
    if (!ocupado) falls <= 0;
    else if (sel_prev && !sel) falls <= falls + 1;
  end

  function automatic logic [5:0] pad_pins(input logic [1:0] k, input logic [11:0] b,
                                          input logic s, input int f);
    logic [5:0] r;
    if (k == 2'd0) r = 6'h3F;
    else if (k == 2'd2 && !s && f == 3)
      r = {~b[BTN_START], ~b[BTN_A], 4'b0000};
    else if (k == 2'd2 && s && f == 3)
      r = {~b[BTN_C], ~b[BTN_B], ~b[BTN_MODE], ~b[BTN_X], ~b[BTN_Y], ~b[BTN_Z]};
    else if (k == 2'd2 && !s && f == 4)
      r = {~b[BTN_START], ~b[BTN_A], 4'b1111};
    else if (s)
      r = {~b[BTN_C], ~b[BTN_B], ~b[BTN_RIGHT], ~b[BTN_LEFT], ~b[BTN_DOWN], ~b[BTN_UP]};
    else
      r = {~b[BTN_START], ~b[BTN_A], 2'b00, ~b[BTN_DOWN], ~b[BTN_UP]};
    return r;
  endfunction

  assign pinos = {pad_pins(kind1, btn1, sel, falls), pad_pins(kind0, btn0, sel, falls)};

  typedef struct {
    logic [1:0]  k0;
    logic [11:0] b0;
    logic [1:0]  k1;
    logic [11:0] b1;
    logic [23:0] e_saidas;
    logic [23:0] e_press;
    logic [1:0]  e_pres;
    logic [1:0]  e_seis;
  } vec_t;

  vec_t tbl [12];
  vec_t exp_q [$];

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One frame: queue the expectation, strobe v_sync, compare at Quadro
  task automatic run_frame(input vec_t v, input int idx);
    vec_t e;
    bit   seen;
    kind0 = v.k0; btn0 = v.b0; kind1 = v.k1; btn1 = v.b1;
    exp_q.push_back(v);
    @(posedge clk); #1 v_sync = 1'b1;
    repeat (5) @(posedge clk);
    #1 v_sync = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(posedge clk); #1;
      if (quadro) seen = 1'b1;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      checks++; errors++;
      $display("FAIL frame%0d_quadro: got no pulse expected one within 100 cycles", idx);
    end else begin
      check($sformatf("frame%0d_saidas", idx), saidas, e.e_saidas);
      check($sformatf("frame%0d_press", idx), press, e.e_press);
      check($sformatf("frame%0d_presente", idx), 24'(presente), 24'(e.e_pres));
      check($sformatf("frame%0d_seis", idx), 24'(seis), 24'(e.e_seis));
      @(posedge clk); #1;
      check($sformatf("frame%0d_press_clear", idx), press, 24'h000000);
    end
  endtask

  initial begin
    logic [11:0] ar, xs, sm;
    logic        exp_sel, exp_ocu, exp_qd;
    int          qcount;

    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [11:0] ar, xs, db, ucm, bb;
    logic        exp_sel, exp_ocu, exp_qd;
    int          qcount;

    ar  = 12'((1 << BTN_A) | (1 << BTN_RIGHT));
    xs  = 12'((1 << BTN_X) | (1 << BTN_START));
    db  = 12'(1 << BTN_DOWN);
    ucm = 12'((1 << BTN_UP) | (1 << BTN_C) | (1 << BTN_MODE));
    bb  = 12'(1 << BTN_B);

    //         k0    b0      k1    b1      saidas             press              pres   seis
    tbl[0]  = '{2'd1, ar,     2'd0, 12'h0, 24'h0,             24'h0,             2'b01, 2'b00};
    tbl[1]  = '{2'd1, ar,     2'd0, 12'h0, {12'h0, ar},       {12'h0, ar},       2'b01, 2'b00};
    tbl[2]  = '{2'd1, ar,     2'd0, 12'h0, {12'h0, ar},       24'h0,             2'b01, 2'b00};
    tbl[3]  = '{2'd2, xs,     2'd0, 12'h0, {12'h0, ar},       24'h0,             2'b01, 2'b01};
    tbl[4]  = '{2'd2, xs,     2'd0, 12'h0, {12'h0, xs},       {12'h0, xs},       2'b01, 2'b01};
    tbl[5]  = '{2'd1, 12'h0,  2'd0, 12'h0, {12'h0, xs},       24'h0,             2'b01, 2'b00};
    tbl[6]  = '{2'd1, 12'h0,  2'd0, 12'h0, 24'h0,             24'h0,             2'b01, 2'b00};
    tbl[7]  = '{2'd1, bb,     2'd0, 12'h0, 24'h0,             24'h0,             2'b01, 2'b00};
    tbl[8]  = '{2'd1, 12'h0,  2'd0, 12'h0, 24'h0,             24'h0,             2'b01, 2'b00};
    tbl[9]  = '{2'd1, 12'h0,  2'd0, 12'h0, 24'h0,             24'h0,             2'b01, 2'b00};
    tbl[10] = '{2'd1, db,     2'd2, ucm,   24'h0,             24'h0,             2'b11, 2'b10};
    tbl[11] = '{2'd1, db,     2'd2, ucm,   {ucm, db},         {ucm, db},         2'b11, 2'b10};

    kind0 = 2'd0; kind1 = 2'd0; btn0 = 12'h0; btn1 = 12'h0;
    v_sync = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_select", 24'(sel), 24'h1);
    check("reset_saidas", saidas, 24'h0);
    check("reset_press", press, 24'h0);
    check("reset_presente", 24'(presente), 24'h0);
    check("reset_seis", 24'(seis), 24'h0);
    check("reset_quadro", 24'(quadro), 24'h0);
    check("reset_ocupado", 24'(ocupado), 24'h0);
    repeat (4) @(posedge clk);

    for (int i = 0; i < 12; i++) run_frame(tbl[i], i);

    // Reset in the middle of phase 3 of a scan
    @(posedge clk); #1 v_sync = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
    end
    check("midscan_select_before", 24'(sel), 24'h0);
    check("midscan_ocupado_before", 24'(ocupado), 24'h1);
    rst = 1'b1; v_sync = 1'b0;
    @(posedge clk); #1;
    check("midscan_select", 24'(sel), 24'h1);
    check("midscan_ocupado", 24'(ocupado), 24'h0);
    check("midscan_saidas", saidas, 24'h0);
    check("midscan_presente", 24'(presente), 24'h0);
    check("midscan_seis", 24'(seis), 24'h0);
    check("midscan_quadro", 24'(quadro), 24'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Cycle-accurate timing from the v_sync rising edge
    kind0 = 2'd1; btn0 = 12'h0; kind1 = 2'd0; btn1 = 12'h0;
    @(posedge clk); #1 v_sync = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 5) v_sync = 1'b0;
      exp_sel = (c >= 3 && c < 35) ? ((((c - 3) / 4) % 2) == 0) : 1'b1;
      exp_ocu = (c >= 3 && c <= 35);
      exp_qd  = (c == 36);
      check($sformatf("timing_select_c%0d", c), 24'(sel), 24'(exp_sel));
      check($sformatf("timing_ocupado_c%0d", c), 24'(ocupado), 24'(exp_ocu));
      check($sformatf("timing_quadro_c%0d", c), 24'(quadro), 24'(exp_qd));
    end
    repeat (3) @(posedge clk);

    // Second edge while busy must be dropped, not queued
    qcount = 0;
    @(posedge clk); #1 v_sync = 1'b1;
    for (int c = 1; c <= 90; c++) begin
      @(posedge clk); #1;
      if (quadro) qcount++;
      if (c == 4) v_sync = 1'b0;
      if (c == 12) begin
        check("busy_edge_ocupado", 24'(ocupado), 24'h1);
        v_sync = 1'b1;
      end
      if (c == 16) v_sync = 1'b0;
    end
    check("busy_edge_quadro_count", 24'(qcount), 24'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
